uart_rx_fifo: RTL

//   8N1 UART receiver with a small receive FIFO. It accepts the serial stream driven by the
//   MSP430 debug/user UART TX pins (debug_uart_tx, user_uart_tx) or by a header pin, and

---
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, and a
// first-word fall-through receive FIFO with frame-error and overrun pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {WAIT_HI, IDLE, START, DATA, STOP} state_t;

  logic          sync1, rs;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok, drop;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      sync1 <= rxd;
      rs    <= sync1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= WAIT_HI;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr      = 1'b0;
    case (state)
      WAIT_HI: begin
        cnt_n = '0;
        if (rs) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = '0;
        if (!rs) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HI;
          end
        end
      end
      default: state_n = WAIT_HI;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      frame_err <= ferr;
      overrun   <= drop;
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
  assign busy     = (state != IDLE);

endmodule
